bram_tdp_cfg: RTL and testbench

Single-clock true dual-port block RAM and the parametrised successor of the fixed read-first TDP RAM. It adds a selectable write mode, per-byte write enables and an optional output register stage. It also adds a power-up zeroing sweep FSM and deterministic same-address collision handling. It is used for register files, scratchpads and cache tag/data arrays in the core.

---
 rtl/bram_tdp_cfg.sv | 207 ++++++++++++++++++++
 tb/tb_bram_tdp_cfg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_tdp_cfg.sv
// -----------------------------------------------------------------------------
// bram_tdp_cfg
//   Single-clock true dual-port block RAM with:
//     - selectable same-port write mode (read-first / write-first / no-change)
//     - per-byte write enables
//     - optional output register stage (read latency 1 or 2)
//     - power-up zeroing sweep (ready_o low until every word is cleared)
//     - deterministic same-address cross-port collision handling
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous reset, active-high
//   ready_o      1 once the init sweep is done; accesses ignored while 0
//   enX_i        port X access enable
//   weX_i        port X byte write enables (all zero = read)
//   addrX_i      port X word address
//   dataX_i      port X write data
//   dataX_o      port X read data (holds when there is no access)
//   validX_o     port X read-data valid, single-cycle pulse
//   collision_o  pulse on a same-address conflict involving a write,
//                aligned with the valid pulses
// -----------------------------------------------------------------------------
module bram_tdp_cfg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int WRITE_MODE = 0,  // 0 read-first, 1 write-first, 2 no-change
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1,
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH,
  localparam int AW        = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  ready_o,
  input  logic                  enA_i,
  input  logic [NUM_BYTES-1:0]  weA_i,
  input  logic [AW-1:0]         addrA_i,
  input  logic [DATA_WIDTH-1:0] dataA_i,
  output logic [DATA_WIDTH-1:0] dataA_o,
  output logic                  validA_o,
  input  logic                  enB_i,
  input  logic [NUM_BYTES-1:0]  weB_i,
  input  logic [AW-1:0]         addrB_i,
  input  logic [DATA_WIDTH-1:0] dataB_i,
  output logic [DATA_WIDTH-1:0] dataB_o,
  output logic                  validB_o,
  output logic                  collision_o
);

  localparam logic [0:0]  ST_INIT  = 1'b0;
  localparam logic [0:0]  ST_READY = 1'b1;
  localparam logic [AW:0] DEPTH    = (AW+1)'(NUM_WORDS);
  localparam logic [AW-1:0] LAST   = AW'(NUM_WORDS - 1);

  // Overlay the enabled byte lanes of wr onto base.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wr,
    input logic [NUM_BYTES-1:0]  we
  );
    merge = base;
    for (int k = 0; k < NUM_BYTES; k++)
      if (we[k]) merge[k*BYTE_WIDTH +: BYTE_WIDTH] = wr[k*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          init_wr;

  // ---------------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (INIT_ZERO == 0 || cnt == LAST) state <= ST_READY;
      else                                cnt   <= cnt + AW'(1);
    end
  end

  assign ready_o = (state == ST_READY);
  assign init_wr = (INIT_ZERO != 0) && (state == ST_INIT) && !rst_i;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic acc_a, acc_b, wr_a, wr_b, in_a, in_b, same_addr, coll;
  logic [DATA_WIDTH-1:0] old_a, old_b;

  assign acc_a = enA_i & ready_o;
  assign acc_b = enB_i & ready_o;
  assign wr_a  = acc_a & (|weA_i);
  assign wr_b  = acc_b & (|weB_i);
  assign in_a  = ({1'b0, addrA_i} < DEPTH);
  assign in_b  = ({1'b0, addrB_i} < DEPTH);
  assign old_a = in_a ? mem[addrA_i] : '0;
  assign old_b = in_b ? mem[addrB_i] : '0;

  // Only in-range addresses can conflict; out-of-range writes are dropped.
  assign same_addr = acc_a & acc_b & in_a & in_b & (addrA_i == addrB_i);
  assign coll      = same_addr & ((wr_a & wr_b) ? |(weA_i & weB_i) : (wr_a | wr_b));

  // Per-port response: data to present and whether the output updates.
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  upd_a, upd_b;

  // NOTE: every combinational output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rd_a  = old_a;
    rd_b  = old_b;
    upd_a = acc_a;
    upd_b = acc_b;
    if (WRITE_MODE == 1) begin
      // Own lanes over the old word; the other port's same-cycle write is not
      // visible, matching the "reader sees old data" rule for cross-port.
      if (wr_a) rd_a = in_a ? merge(old_a, dataA_i, weA_i) : '0;
      if (wr_b) rd_b = in_b ? merge(old_b, dataB_i, weB_i) : '0;
    end else if (WRITE_MODE == 2) begin
      if (wr_a) upd_a = 1'b0;
      if (wr_b) upd_b = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Port A's lanes are written last so A wins per lane on a
  // same-address double write, while B's non-overlapping lanes survive.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; clearing it is the job of the init sweep,
  // which keeps it mappable to block RAM.
  always_ff @(posedge clk_i) begin
    if (init_wr) mem[cnt] <= '0;
    if (wr_b && in_b)
      for (int k = 0; k < NUM_BYTES; k++)
        if (weB_i[k]) mem[addrB_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= dataB_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    if (wr_a && in_a)
      for (int k = 0; k < NUM_BYTES; k++)
        if (weA_i[k]) mem[addrA_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= dataA_i[k*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // First output stage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
  logic                  valid_a_q, valid_b_q, coll_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_a_q  <= '0;
      data_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      valid_a_q <= upd_a;
      valid_b_q <= upd_b;
      coll_q    <= coll;
      if (upd_a) data_a_q <= rd_a;
      if (upd_b) data_b_q <= rd_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional second stage: always advances; holding data is inherited from
  // the first stage, which only loads on an access.
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] data_a_q2, data_b_q2;
    logic                  valid_a_q2, valid_b_q2, coll_q2;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_a_q2  <= '0;
        data_b_q2  <= '0;
        valid_a_q2 <= 1'b0;
        valid_b_q2 <= 1'b0;
        coll_q2    <= 1'b0;
      end else begin
        data_a_q2  <= data_a_q;
        data_b_q2  <= data_b_q;
        valid_a_q2 <= valid_a_q;
        valid_b_q2 <= valid_b_q;
        coll_q2    <= coll_q;
      end
    end

    assign dataA_o     = data_a_q2;
    assign dataB_o     = data_b_q2;
    assign validA_o    = valid_a_q2;
    assign validB_o    = valid_b_q2;
    assign collision_o = coll_q2;
  end else begin : g_no_out_reg
    assign dataA_o     = data_a_q;
    assign dataB_o     = data_b_q;
    assign validA_o    = valid_a_q;
    assign validB_o    = valid_b_q;
    assign collision_o = coll_q;
  end

endmodule

// File: tb/tb_bram_tdp_cfg.sv
// -----------------------------------------------------------------------------
// tb_bram_tdp_cfg
//   Four instances share one stimulus stream:
//     u0: read-first,  OUT_REG=0, 32 words, init sweep
//     u1: write-first, OUT_REG=1, 24 words, init sweep
//     u2: no-change,   OUT_REG=0, 32 words, init sweep
//     u3: read-first,  OUT_REG=0, 32 words, no init sweep
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, i.e. they show the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_bram_tdp_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  we_a = '0, we_b = '0;
  logic [4:0]  addr_a = '0, addr_b = '0;
  logic [31:0] wd_a = '0, wd_b = '0;

  logic [3:0]  rdy, va, vb, col;
  logic [31:0] da [4];
  logic [31:0] db [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_tdp_cfg #(.WRITE_MODE(0), .OUT_REG(0), .NUM_WORDS(32), .INIT_ZERO(1)) u0 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[0]),
    .enA_i(en_a), .weA_i(we_a), .addrA_i(addr_a), .dataA_i(wd_a), .dataA_o(da[0]), .validA_o(va[0]),
    .enB_i(en_b), .weB_i(we_b), .addrB_i(addr_b), .dataB_i(wd_b), .dataB_o(db[0]), .validB_o(vb[0]),
    .collision_o(col[0]));

  bram_tdp_cfg #(.WRITE_MODE(1), .OUT_REG(1), .NUM_WORDS(24), .INIT_ZERO(1)) u1 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[1]),
    .enA_i(en_a), .weA_i(we_a), .addrA_i(addr_a), .dataA_i(wd_a), .dataA_o(da[1]), .validA_o(va[1]),
    .enB_i(en_b), .weB_i(we_b), .addrB_i(addr_b), .dataB_i(wd_b), .dataB_o(db[1]), .validB_o(vb[1]),
    .collision_o(col[1]));

  bram_tdp_cfg #(.WRITE_MODE(2), .OUT_REG(0), .NUM_WORDS(32), .INIT_ZERO(1)) u2 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[2]),
    .enA_i(en_a), .weA_i(we_a), .addrA_i(addr_a), .dataA_i(wd_a), .dataA_o(da[2]), .validA_o(va[2]),
    .enB_i(en_b), .weB_i(we_b), .addrB_i(addr_b), .dataB_i(wd_b), .dataB_o(db[2]), .validB_o(vb[2]),
    .collision_o(col[2]));

  bram_tdp_cfg #(.WRITE_MODE(0), .OUT_REG(0), .NUM_WORDS(32), .INIT_ZERO(0)) u3 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[3]),
    .enA_i(en_a), .weA_i(we_a), .addrA_i(addr_a), .dataA_i(wd_a), .dataA_o(da[3]), .validA_o(va[3]),
    .enB_i(en_b), .weB_i(we_b), .addrB_i(addr_b), .dataB_i(wd_b), .dataB_o(db[3]), .validB_o(vb[3]),
    .collision_o(col[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic [3:0] we, input logic [4:0] addr, input logic [31:0] d);
    en_a = en; we_a = we; addr_a = addr; wd_a = d;
  endtask

  task automatic set_b(input logic en, input logic [3:0] we, input logic [4:0] addr, input logic [31:0] d);
    en_b = en; we_b = we; addr_b = addr; wd_b = d;
  endtask

  initial begin
    int ready_at0, ready_at1, ready_at3, init_valid;

    // ---------------- reset ----------------
    tick; tick; tick;
    check("rst_outputs_u0", {rdy[0], va[0], vb[0], col[0], da[0]}, 64'h0);
    check("rst_outputs_u1", {rdy[1], va[1], vb[1], col[1], db[1]}, 64'h0);
    check("rst_ready_u3", {63'h0, rdy[3]}, 64'h0);

    // ---------------- init sweep, with enA pulses ----------------
    @(posedge clk); #1; rst = 1'b0;
    ready_at0 = 0; ready_at1 = 0; ready_at3 = 0; init_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      set_a(i <= 5, 4'h0, 5'd0, 32'h0);
      tick;
      if (rdy[0] && ready_at0 == 0) ready_at0 = i;
      if (rdy[1] && ready_at1 == 0) ready_at1 = i;
      if (rdy[3] && ready_at3 == 0) ready_at3 = i;
      if (!rdy[0] && va[0]) init_valid++;
    end
    check("ready_delay_u0", 64'(ready_at0), 64'd32);
    check("ready_delay_u1", 64'(ready_at1), 64'd24);
    check("ready_delay_u3", 64'(ready_at3), 64'd1);
    check("init_no_valid", 64'(init_valid), 64'd0);

    // ---------------- sweep left zeros everywhere ----------------
    for (int a = 0; a < 32; a++) begin
      set_a(1'b1, 4'h0, 5'(a), 32'h0);
      tick;
      check($sformatf("zero_rd_%0d", a), {va[0], da[0]}, {1'b1, 32'h0});
    end

    // ---------------- read-first vs write-first ----------------
    set_a(1'b1, 4'hF, 5'd5, 32'hDEADBEEF); tick;
    check("rf_first_old", {va[0], da[0]}, {1'b1, 32'h0});
    set_a(1'b1, 4'hF, 5'd5, 32'h12345678); tick;
    check("rf_second_old", {va[0], da[0]}, {1'b1, 32'hDEADBEEF});
    check("wf_first_new", {va[1], da[1]}, {1'b1, 32'hDEADBEEF});
    check("nc_write_hold", {va[2], da[2]}, {1'b0, 32'h0});
    set_a(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("wf_second_new", {va[1], da[1]}, {1'b1, 32'h12345678});
    check("rf_idle_hold", {va[0], da[0]}, {1'b0, 32'hDEADBEEF});
    tick;
    check("wf_idle_hold", {va[1], da[1]}, {1'b0, 32'h12345678});

    // ---------------- byte enables ----------------
    set_a(1'b1, 4'hF, 5'd3, 32'hAABBCCDD); tick;
    set_a(1'b1, 4'b0101, 5'd3, 32'h11223344); tick;
    check("be_rf_old", {va[0], da[0]}, {1'b1, 32'hAABBCCDD});
    set_a(1'b1, 4'h0, 5'd3, 32'h0); tick;
    check("be_read_u0", {va[0], da[0]}, {1'b1, 32'hAA22CC44});
    check("be_wf_merged", {va[1], da[1]}, {1'b1, 32'hAA22CC44});
    check("be_read_u2", {va[2], da[2]}, {1'b1, 32'hAA22CC44});
    set_a(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("be_read_u1", {va[1], da[1]}, {1'b1, 32'hAA22CC44});

    // ---------------- double write, full overlap ----------------
    set_a(1'b1, 4'hF, 5'd7, 32'h1);
    set_b(1'b1, 4'hF, 5'd7, 32'h2); tick;
    check("ww_coll_u0", {63'h0, col[0]}, 64'h1);
    check("ww_coll_u1_delayed", {63'h0, col[1]}, 64'h0);
    check("ww_old_a", {va[0], da[0]}, {1'b1, 32'h0});
    set_a(1'b1, 4'h0, 5'd7, 32'h0);
    set_b(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("ww_a_wins", {va[0], da[0]}, {1'b1, 32'h1});
    check("ww_coll_pulse_end", {63'h0, col[0]}, 64'h0);
    check("ww_coll_u1", {63'h0, col[1]}, 64'h1);
    set_a(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("ww_read_u1", {va[1], da[1], col[1]}, {1'b1, 32'h1, 1'b0});

    // ---------------- read vs write ----------------
    set_a(1'b1, 4'hF, 5'd9, 32'h99); tick;
    set_a(1'b1, 4'h0, 5'd9, 32'h0);
    set_b(1'b1, 4'hF, 5'd9, 32'h55); tick;
    check("rw_reader_old", {va[0], da[0]}, {1'b1, 32'h99});
    check("rw_coll", {63'h0, col[0]}, 64'h1);
    set_a(1'b0, 4'h0, 5'd0, 32'h0);
    set_b(1'b1, 4'h0, 5'd9, 32'h0); tick;
    check("rw_written", {vb[0], db[0]}, {1'b1, 32'h55});
    check("rw_no_coll", {63'h0, col[0]}, 64'h0);

    // ---------------- double write, disjoint lanes ----------------
    set_a(1'b1, 4'b0011, 5'd10, 32'h0000AAAA);
    set_b(1'b1, 4'b1100, 5'd10, 32'hBBBB0000); tick;
    check("disjoint_no_coll", {63'h0, col[0]}, 64'h0);
    set_a(1'b1, 4'h0, 5'd10, 32'h0);
    set_b(1'b1, 4'h0, 5'd10, 32'h0); tick;
    check("rr_no_coll", {63'h0, col[0]}, 64'h0);
    check("disjoint_a", {va[0], da[0]}, {1'b1, 32'hBBBBAAAA});
    check("disjoint_b", {vb[0], db[0]}, {1'b1, 32'hBBBBAAAA});

    // ---------------- double write, partial overlap ----------------
    set_a(1'b1, 4'b0001, 5'd11, 32'h00000011);
    set_b(1'b1, 4'b0011, 5'd11, 32'h00002222); tick;
    check("partial_coll", {63'h0, col[0]}, 64'h1);
    set_a(1'b1, 4'h0, 5'd11, 32'h0);
    set_b(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("partial_lanes", {va[0], da[0]}, {1'b1, 32'h00002211});

    // ---------------- no-change mode ----------------
    set_a(1'b1, 4'hF, 5'd2, 32'hCAFEF00D); tick;
    check("nc_wr_no_valid", {63'h0, va[2]}, 64'h0);
    set_a(1'b1, 4'h0, 5'd2, 32'h0); tick;
    check("nc_read", {va[2], da[2]}, {1'b1, 32'hCAFEF00D});
    set_a(1'b1, 4'hF, 5'd2, 32'h0BADBEEF); tick;
    check("nc_write_holds", {va[2], da[2]}, {1'b0, 32'hCAFEF00D});
    check("nc_rf_ref", {va[0], da[0]}, {1'b1, 32'hCAFEF00D});
    set_a(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("nc_idle_holds", {va[2], da[2]}, {1'b0, 32'hCAFEF00D});

    // ---------------- out of range on the 24-word instance ----------------
    set_a(1'b1, 4'hF, 5'd30, 32'hFFFFFFFF); tick;
    set_a(1'b1, 4'h0, 5'd30, 32'h0); tick;
    check("range_in_u0", {va[0], da[0]}, {1'b1, 32'hFFFFFFFF});
    check("range_wr_u1", {va[1], da[1]}, {1'b1, 32'h0});
    set_a(1'b0, 4'h0, 5'd0, 32'h0); tick;
    check("range_rd_u1", {va[1], da[1]}, {1'b1, 32'h0});

    // ---------------- reset mid-operation and mid-sweep ----------------
    rst = 1'b1; tick;
    check("rst2_u0", {rdy[0], va[0], vb[0], col[0], da[0]}, 64'h0);
    check("rst2_u0_b", {32'h0, db[0]}, 64'h0);
    check("rst2_u1", {rdy[1], va[1], col[1], da[1]}, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    rst = 1'b1; tick;
    check("rst3_ready", {62'h0, rdy[1], rdy[0]}, 64'h0);
    rst = 1'b0;
    ready_at0 = 0; ready_at1 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (rdy[0] && ready_at0 == 0) ready_at0 = i;
      if (rdy[1] && ready_at1 == 0) ready_at1 = i;
    end
    check("restart_delay_u0", 64'(ready_at0), 64'd32);
    check("restart_delay_u1", 64'(ready_at1), 64'd24);
    set_a(1'b1, 4'h0, 5'd5, 32'h0); tick;
    check("restart_zeroed", {va[0], da[0]}, {1'b1, 32'h0});
    set_a(1'b0, 4'h0, 5'd0, 32'h0); tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
